// File: rtl/crop_pkg.sv
// Shared types, geometry constants and the origin bounds check for the crop scheduler.
package crop_pkg;

    localparam int unsigned IN_ROWS   = 9;
    localparam int unsigned IN_COLS   = 9;
    localparam int unsigned OUT_ROWS  = 3;
    localparam int unsigned OUT_COLS  = 3;
    localparam int unsigned MAX_CROPS = 4;

    localparam int unsigned CW        = $clog2((IN_ROWS > IN_COLS) ? IN_ROWS : IN_COLS);
    localparam int unsigned IDX_W     = $clog2(MAX_CROPS);
    localparam int unsigned CNT_W     = $clog2(MAX_CROPS + 1);
    localparam int unsigned FRAME_PIX = IN_ROWS * IN_COLS;
    localparam int unsigned CROP_PIX  = OUT_ROWS * OUT_COLS;
    localparam int unsigned IN_CNT_W  = $clog2(FRAME_PIX + 1);
    localparam int unsigned OUT_CNT_W = $clog2(CROP_PIX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_REQ,
        ST_RUN,
        ST_DONE
    } crop_state_t;

    typedef struct packed {
        logic [CW-1:0] y;
        logic [CW-1:0] x;
    } crop_origin_t;

    // The whole crop window must lie inside the input frame.
    function automatic logic origin_in_bounds(input crop_origin_t o);
        return ((32'(o.y) + OUT_ROWS) <= IN_ROWS) && ((32'(o.x) + OUT_COLS) <= IN_COLS);
    endfunction

endpackage

// File: rtl/crop_origin_table.sv
// Origin register file: accepts load beats, tracks list count, open/closed state and the sticky error.
module crop_origin_table
    import crop_pkg::*;
(
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr_valid,
    input  crop_origin_t         i_wr_origin,
    input  logic                 i_wr_last,
    input  logic [IDX_W-1:0]     i_rd_idx,
    output crop_origin_t         o_rd_origin,
    output logic [CNT_W-1:0]     o_count,
    output logic [CNT_W-1:0]     o_count_nxt,
    output logic                 o_err
);

    crop_origin_t     r_tab [MAX_CROPS];
    logic [CNT_W-1:0] r_count;
    logic             r_closed;
    logic             r_err;

    logic             w_ok;
    logic             w_store;
    logic [CNT_W-1:0] w_base;
    logic [CNT_W-1:0] w_count_nxt;

    // A beat arriving on a closed list starts a fresh list at slot 0.
    always_comb begin
        w_ok        = origin_in_bounds(i_wr_origin);
        w_base      = r_closed ? '0 : r_count;
        w_store     = i_wr_valid && w_ok;
        w_count_nxt = r_count;
        if (i_wr_valid) begin
            w_count_nxt = w_base + CNT_W'(w_ok);
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < MAX_CROPS; i++) begin
                r_tab[i] <= '0;
            end
            r_count  <= '0;
            r_closed <= 1'b0;
            r_err    <= 1'b0;
        end else if (i_wr_valid) begin
            if (w_ok) begin
                r_tab[w_base[IDX_W-1:0]] <= i_wr_origin;
            end
            r_count  <= w_count_nxt;
            r_err    <= (r_closed ? 1'b0 : r_err) | ~w_ok;
            r_closed <= i_wr_last || (w_count_nxt == CNT_W'(MAX_CROPS));
        end
    end

    // Forward a same-cycle write so a start in the load cycle sees the new origin.
    assign o_rd_origin = (w_store && (w_base[IDX_W-1:0] == i_rd_idx)) ? i_wr_origin
                                                                      : r_tab[i_rd_idx];
    assign o_count     = r_count;
    assign o_count_nxt = w_count_nxt;
    assign o_err       = r_err;

endmodule

// File: rtl/crop_scheduler.sv
// Crop sequencing controller: runs one replayed frame per stored origin and gates the
// source/datapath/sink handshakes so exactly one frame enters and one crop leaves per entry.
module crop_scheduler
    import crop_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CW-1:0]     cfg_y,
    input  logic [CW-1:0]     cfg_x,
    input  logic              cfg_last,
    output logic              cfg_err,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              frame_req,
    input  logic              frame_ack,
    output logic              dp_clear,
    output logic [CW-1:0]     crop_y,
    output logic [CW-1:0]     crop_x,
    input  logic              up_valid,
    output logic              up_ready,
    output logic              dp_in_valid,
    input  logic              dp_in_ready,
    input  logic              dp_out_valid,
    output logic              dp_out_ready,
    output logic              down_valid,
    input  logic              down_ready,
    output logic [IDX_W-1:0]  out_crop_idx,
    output logic              out_last,
    output crop_state_t       dbg_state
);

    crop_state_t            r_state;
    logic [IDX_W-1:0]       r_k;
    logic [IN_CNT_W-1:0]    r_in_cnt;
    logic [OUT_CNT_W-1:0]   r_out_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_dp_clear;
    logic                   r_frame_req;
    crop_origin_t           r_crop;

    logic                   w_wr;
    logic [IDX_W-1:0]       w_rd_idx;
    crop_origin_t           w_rd_origin;
    logic [CNT_W-1:0]       w_count;
    logic [CNT_W-1:0]       w_count_nxt;
    logic                   w_in_open;
    logic                   w_out_open;
    logic                   w_in_hs;
    logic                   w_out_hs;
    logic [IN_CNT_W-1:0]    w_in_cnt_nxt;
    logic [OUT_CNT_W-1:0]   w_out_cnt_nxt;
    logic                   w_both_full;
    logic                   w_more;

    assign cfg_ready = (r_state == ST_IDLE) && (w_count < CNT_W'(MAX_CROPS));
    assign w_wr      = cfg_valid && cfg_ready;
    assign w_rd_idx  = (r_state == ST_IDLE) ? '0 : r_k + 1'b1;

    crop_origin_table u_table (
        .clk         (clk),
        .i_rst_n     (reset),
        .i_wr_valid  (w_wr),
        .i_wr_origin ({cfg_y, cfg_x}),
        .i_wr_last   (cfg_last),
        .i_rd_idx    (w_rd_idx),
        .o_rd_origin (w_rd_origin),
        .o_count     (w_count),
        .o_count_nxt (w_count_nxt),
        .o_err       (cfg_err)
    );

    // Valid/ready: a beat moves when valid and ready are both high at a rising edge;
    // gating only ever removes both sides of a pair together, so no beat is half-taken.
    assign w_in_open     = (r_state == ST_RUN) && (r_in_cnt < IN_CNT_W'(FRAME_PIX));
    assign w_out_open    = (r_state == ST_RUN) && (r_out_cnt < OUT_CNT_W'(CROP_PIX));
    assign dp_in_valid   = up_valid && w_in_open;
    assign up_ready      = dp_in_ready && w_in_open;
    assign down_valid    = dp_out_valid && w_out_open;
    assign dp_out_ready  = down_ready && w_out_open;
    assign w_in_hs       = up_valid && dp_in_ready && w_in_open;
    assign w_out_hs      = dp_out_valid && down_ready && w_out_open;
    assign w_in_cnt_nxt  = r_in_cnt + IN_CNT_W'(w_in_hs);
    assign w_out_cnt_nxt = r_out_cnt + OUT_CNT_W'(w_out_hs);
    assign w_both_full   = (w_in_cnt_nxt == IN_CNT_W'(FRAME_PIX)) &&
                           (w_out_cnt_nxt == OUT_CNT_W'(CROP_PIX));
    assign w_more        = (CNT_W'(r_k) + CNT_W'(1)) < w_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dp_clear  <= 1'b0;
            r_frame_req <= 1'b0;
            r_crop      <= '0;
        end else begin
            r_done     <= 1'b0;
            r_dp_clear <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_count_nxt != '0) begin
                            r_state    <= ST_ARM;
                            r_k        <= '0;
                            r_busy     <= 1'b1;
                            r_dp_clear <= 1'b1;
                            r_crop     <= w_rd_origin;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_ARM: begin
                    r_state     <= ST_REQ;
                    r_frame_req <= 1'b1;
                end
                ST_REQ: begin
                    if (frame_ack) begin
                        r_state     <= ST_RUN;
                        r_frame_req <= 1'b0;
                        r_in_cnt    <= '0;
                        r_out_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_in_cnt  <= w_in_cnt_nxt;
                    r_out_cnt <= w_out_cnt_nxt;
                    if (w_both_full) begin
                        if (w_more) begin
                            r_state    <= ST_ARM;
                            r_k        <= r_k + 1'b1;
                            r_dp_clear <= 1'b1;
                            r_crop     <= w_rd_origin;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign dp_clear     = r_dp_clear;
    assign frame_req    = r_frame_req;
    assign crop_y       = r_crop.y;
    assign crop_x       = r_crop.x;
    assign out_crop_idx = r_k;
    assign out_last     = (r_state == ST_RUN) && (r_out_cnt == OUT_CNT_W'(CROP_PIX - 1));
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_crop_scheduler.sv
// Bench for crop_scheduler: directed list scenarios, randomized handshakes and a mid-run reset.
module tb_crop_scheduler;
    import crop_pkg::*;

    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_REQ  = 2;
    localparam int P_RUN  = 3;
    localparam int P_DONE = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic              cfg_valid = 0, cfg_last = 0, start = 0, frame_ack = 0;
    logic [CW-1:0]     cfg_y = '0, cfg_x = '0;
    logic              up_valid = 0, dp_in_ready = 0, dp_out_valid = 0, down_ready = 0;
    logic              cfg_ready, cfg_err, busy, done, frame_req, dp_clear;
    logic [CW-1:0]     crop_y, crop_x;
    logic              up_ready, dp_in_valid, dp_out_ready, down_valid, out_last;
    logic [IDX_W-1:0]  out_crop_idx;
    crop_state_t       dbg_state;

    crop_scheduler dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_y(cfg_y), .cfg_x(cfg_x),
        .cfg_last(cfg_last), .cfg_err(cfg_err), .start(start), .busy(busy), .done(done),
        .frame_req(frame_req), .frame_ack(frame_ack), .dp_clear(dp_clear),
        .crop_y(crop_y), .crop_x(crop_x), .up_valid(up_valid), .up_ready(up_ready),
        .dp_in_valid(dp_in_valid), .dp_in_ready(dp_in_ready), .dp_out_valid(dp_out_valid),
        .dp_out_ready(dp_out_ready), .down_valid(down_valid), .down_ready(down_ready),
        .out_crop_idx(out_crop_idx), .out_last(out_last), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- environment: source/datapath/sink and frame replay ----------------
    bit stim_rand = 0;
    bit spurious_ack = 0;
    bit req_pend = 0;
    int ack_lat = 0;
    int ack_wait = 0;

    always @(posedge clk) begin
        #1;
        if (stim_rand) begin
            up_valid     = ($urandom_range(0, 3) != 0);
            dp_in_ready  = ($urandom_range(0, 3) != 0);
            dp_out_valid = ($urandom_range(0, 3) != 0);
            down_ready   = ($urandom_range(0, 3) != 0);
        end else begin
            up_valid = 1; dp_in_ready = 1; dp_out_valid = 1; down_ready = 1;
        end
        if (!reset) begin
            frame_ack = 0; req_pend = 0;
        end else if (frame_req) begin
            if (!req_pend) begin
                req_pend = 1; ack_lat = $urandom_range(0, 3); ack_wait = 0;
            end
            frame_ack = (ack_wait == ack_lat);
            ack_wait++;
        end else begin
            req_pend = 0;
            frame_ack = spurious_ack && ($urandom_range(0, 15) == 0);
        end
    end

    // ---------------- scoreboard: list model and per-cycle compare ----------------
    logic [2*CW-1:0] exp_q[$];      // model origin table in load order
    bit m_closed, m_err, m_idle_done;
    int m_ph, m_k, m_in, m_out;

    // logs derived only from observed DUT traffic, cleared on each epoch bump
    int epoch = 0, seen_epoch = 0, cyc = 0;
    int tot_in, tot_out, last_cnt, done_cnt, busy_cnt, crop_in, crop_out;
    int last_in_cyc, last_out_cyc, done_cyc;
    bit seen_crop;
    logic [2*CW-1:0] clr_log[$];
    int idx_log[$];

    always @(negedge clk) begin
        bit run, in_open, out_open;
        cyc++;
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            tot_in = 0; tot_out = 0; last_cnt = 0; done_cnt = 0; busy_cnt = 0;
            last_in_cyc = 0; last_out_cyc = 0; done_cyc = 0;
            clr_log.delete(); idx_log.delete();
        end
        if (!reset) begin
            exp_q.delete();
            m_closed = 0; m_err = 0; m_idle_done = 0;
            m_ph = P_IDLE; m_k = 0; m_in = 0; m_out = 0; seen_crop = 0;
            check("rst_cfg_ready", cfg_ready, 1);
            check("rst_cfg_err", cfg_err, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_frame_req", frame_req, 0);
            check("rst_dp_clear", dp_clear, 0);
            check("rst_crop", {crop_y, crop_x}, 0);
            check("rst_gating", {up_ready, dp_in_valid, dp_out_ready, down_valid}, 0);
            check("rst_idx_last", {out_crop_idx, out_last}, 0);
        end else begin
            run      = (m_ph == P_RUN);
            in_open  = run && (m_in < FRAME_PIX);
            out_open = run && (m_out < CROP_PIX);
            check("cfg_ready", cfg_ready, (m_ph == P_IDLE) && (exp_q.size() < MAX_CROPS));
            check("cfg_err", cfg_err, m_err);
            check("busy", busy, m_ph != P_IDLE);
            check("done", done, (m_ph == P_DONE) || m_idle_done);
            check("dp_clear", dp_clear, m_ph == P_ARM);
            check("frame_req", frame_req, m_ph == P_REQ);
            check("up_ready", up_ready, in_open && dp_in_ready);
            check("dp_in_valid", dp_in_valid, in_open && up_valid);
            check("down_valid", down_valid, out_open && dp_out_valid);
            check("dp_out_ready", dp_out_ready, out_open && down_ready);
            check("out_last", out_last, run && (m_out == CROP_PIX - 1));
            if (m_ph == P_ARM || m_ph == P_REQ || m_ph == P_RUN)
                check("crop_origin", {crop_y, crop_x}, exp_q[m_k]);
            if (run) check("out_crop_idx", out_crop_idx, m_k);

            if (busy) busy_cnt++;
            if (dp_in_valid && dp_in_ready) begin
                crop_in++; tot_in++; last_in_cyc = cyc;
            end
            if (down_valid && down_ready) begin
                crop_out++; tot_out++; last_out_cyc = cyc;
                if (out_last) begin
                    last_cnt++;
                    idx_log.push_back(out_crop_idx);
                    check("last_position", crop_out, CROP_PIX);
                end
            end
            if (dp_clear || done) begin
                if (seen_crop) begin
                    check("crop_inputs", crop_in, 81);
                    check("crop_outputs", crop_out, 9);
                end
                seen_crop = dp_clear;
                crop_in = 0; crop_out = 0;
            end
            if (dp_clear) clr_log.push_back({crop_y, crop_x});
            if (done) begin done_cnt++; done_cyc = cyc; end

            m_idle_done = 0;
            case (m_ph)
                P_IDLE: begin
                    if (cfg_valid && exp_q.size() < MAX_CROPS) begin
                        if (m_closed) begin exp_q.delete(); m_err = 0; m_closed = 0; end
                        if (int'(cfg_y) + OUT_ROWS <= IN_ROWS && int'(cfg_x) + OUT_COLS <= IN_COLS)
                            exp_q.push_back({cfg_y, cfg_x});
                        else
                            m_err = 1;
                        if (cfg_last || exp_q.size() == MAX_CROPS) m_closed = 1;
                    end
                    if (start) begin
                        if (exp_q.size() > 0) begin m_ph = P_ARM; m_k = 0; end
                        else m_idle_done = 1;
                    end
                end
                P_ARM: m_ph = P_REQ;
                P_REQ: if (frame_ack) begin m_ph = P_RUN; m_in = 0; m_out = 0; end
                P_RUN: begin
                    if (up_valid && dp_in_ready && m_in < FRAME_PIX) m_in++;
                    if (dp_out_valid && down_ready && m_out < CROP_PIX) m_out++;
                    if (m_in == FRAME_PIX && m_out == CROP_PIX) begin
                        if (m_k + 1 < exp_q.size()) begin m_k++; m_ph = P_ARM; end
                        else m_ph = P_DONE;
                    end
                end
                default: m_ph = P_IDLE;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1 reset = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
    endtask

    task automatic cfg_beat(input logic [CW-1:0] y, input logic [CW-1:0] x,
                            input bit last, input bit with_start, output bit acc);
        @(posedge clk); #1;
        cfg_valid = 1; cfg_y = y; cfg_x = x; cfg_last = last; start = with_start; acc = 0;
        for (int i = 0; i < 4 && !acc; i++) begin
            @(negedge clk);
            start = 0;
            if (cfg_ready) acc = 1;
            else begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        cfg_valid = 0; cfg_last = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check(nm, seen, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int n, found, last_hs;
        repeat (3) @(posedge clk);
        #1 reset = 1;

        // single centred crop, everything always ready
        cfg_beat(2, 2, 1, 0, acc);
        check("s1_accepted", acc, 1);
        epoch++;
        pulse_start();
        wait_done("s1_done", 2000);
        check("s1_inputs", tot_in, 81);
        check("s1_outputs", tot_out, 9);
        check("s1_last_count", last_cnt, 1);
        check("s1_clears", clr_log.size(), 1);
        if (clr_log.size() == 1) check("s1_origin", clr_log[0], 'h22);
        if (idx_log.size() == 1) check("s1_idx", idx_log[0], 0);
        last_hs = (last_in_cyc > last_out_cyc) ? last_in_cyc : last_out_cyc;
        check("s1_done_latency", done_cyc - last_hs, 1);

        // three origins run in load order (reloads over the closed list)
        cfg_beat(0, 0, 0, 0, acc);
        cfg_beat(6, 6, 0, 0, acc);
        cfg_beat(3, 1, 1, 0, acc);
        epoch++;
        pulse_start();
        wait_done("s2_done", 4000);
        check("s2_clears", clr_log.size(), 3);
        if (clr_log.size() == 3) begin
            check("s2_origin0", clr_log[0], 'h00);
            check("s2_origin1", clr_log[1], 'h66);
            check("s2_origin2", clr_log[2], 'h31);
        end
        check("s2_lasts", idx_log.size(), 3);
        if (idx_log.size() == 3) begin
            check("s2_idx0", idx_log[0], 0);
            check("s2_idx1", idx_log[1], 1);
            check("s2_idx2", idx_log[2], 2);
        end

        // out-of-bounds origin is rejected and leaves an empty list
        cfg_beat(7, 0, 1, 0, acc);
        @(negedge clk);
        check("s3_cfg_err", cfg_err, 1);
        epoch++;
        pulse_start();
        wait_done("s3_done", 20);
        check("s3_busy_cycles", busy_cnt, 0);
        check("s3_done_pulses", done_cnt, 1);

        // five beats into a four-entry table
        cfg_beat(0, 0, 0, 0, acc);
        cfg_beat(1, 1, 0, 0, acc);
        cfg_beat(2, 2, 0, 0, acc);
        cfg_beat(3, 3, 0, 0, acc);
        @(negedge clk);
        check("s4_ready_after_fourth", cfg_ready, 0);
        cfg_beat(4, 4, 1, 0, acc);
        check("s4_fifth_accepted", acc, 0);
        epoch++;
        pulse_start();
        wait_done("s4_done", 5000);
        check("s4_crops_run", clr_log.size(), 4);

        // randomized lists and handshakes, with spurious acks and starts while busy
        do_reset();
        stim_rand = 1;
        spurious_ack = 1;
        for (int it = 0; it < 60; it++) begin
            @(negedge clk);
            if (!cfg_ready) do_reset();
            n = $urandom_range(1, 4);
            for (int b = 0; b < n; b++)
                cfg_beat(CW'($urandom_range(0, 8)), CW'($urandom_range(0, 8)), b == n - 1,
                         (b == n - 1) && ($urandom_range(0, 2) == 0), acc);
            if (!dut.busy && !done) pulse_start();
            repeat (20) @(posedge clk);
            #1 start = 1;
            @(posedge clk); #1 start = 0;
            wait_done("rand_done", 8000);
        end

        // reset in the middle of the second crop
        stim_rand = 0;
        spurious_ack = 0;
        do_reset();
        cfg_beat(0, 0, 0, 0, acc);
        cfg_beat(3, 3, 0, 0, acc);
        cfg_beat(6, 6, 1, 0, acc);
        pulse_start();
        found = 0;
        for (int i = 0; i < 3000 && found == 0; i++) begin
            @(negedge clk); #1;
            if (m_ph == P_RUN && m_k == 1 && m_in == 40) found = 1;
        end
        check("s6_reached_mid_run", found, 1);
        reset = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        epoch++;
        pulse_start();
        wait_done("s6_empty_done", 20);
        check("s6_empty_busy", busy_cnt, 0);
        cfg_beat(1, 1, 0, 0, acc);
        cfg_beat(2, 2, 1, 0, acc);
        epoch++;
        pulse_start();
        wait_done("s6_fresh_done", 3000);
        check("s6_fresh_crops", clr_log.size(), 2);
        check("s6_fresh_outputs", tot_out, 18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
